// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, padding constant and padder state encoding.
package sha256_pkg;

   typedef logic [31:0] word_t;

   // First padding word: a single '1' bit followed by zeros.
   localparam word_t PAD_WORD = 32'h8000_0000;

   // Words per 512-bit block.
   localparam int BLK_WORDS = 16;

   // One-hot, matching the encoding style of sha256_block.
   typedef enum logic [2:0] {
      FILL = 3'b001,
      PAD  = 3'b010,
      EMIT = 3'b100
   } pad_state_t;

endpackage : sha256_pkg

// File: rtl/sha256_msg_padder.sv
// Turns a stream of 32-bit big-endian message words into SHA-256 padded
// 512-bit blocks for sha256_block, flagging the first and final block of each message.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_word,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] out_block,
   output logic         out_first,
   output logic         out_last
);

   pad_state_t       state;
   word_t            blk [BLK_WORDS];
   logic [3:0]       wi;          // next word slot in blk
   logic [CNT_W-1:0] wcnt;        // message words accepted so far
   logic             pad_done;    // PAD_WORD already written for this message
   logic             msg_end;     // final message word has been accepted
   logic             no_len;      // PAD_WORD took slot 14, so this block cannot carry the length
   logic             first_pend;  // next emitted block is the first of its message
   logic [63:0]      len;

   // Message length in bits; wcnt is frozen from the last word until the final block leaves.
   assign len = 64'(wcnt) << 5;

   assign in_ready  = (state == FILL);
   assign out_valid = (state == EMIT);

   // Present the block buffer as one flat vector, word 0 in the top bits.
   // NOTE: a default assignment ahead of the loop keeps every bit driven on every path, so no latch is inferred.
   always_comb begin
      out_block = '0;
      for (int i = 0; i < BLK_WORDS; i++) begin
         out_block[511 - 32*i -: 32] = blk[i];
      end
   end

   // Fill / pad / emit sequencer and block buffer.
   // NOTE: the block buffer is reset because out_block must read as zero out of reset;
   // without that requirement it would be left unreset like any other datapath storage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= FILL;
         wi         <= '0;
         wcnt       <= '0;
         pad_done   <= 1'b0;
         msg_end    <= 1'b0;
         no_len     <= 1'b0;
         first_pend <= 1'b1;
         out_first  <= 1'b0;
         out_last   <= 1'b0;
         for (int i = 0; i < BLK_WORDS; i++) begin
            blk[i] <= '0;
         end
      end else begin
         // NOTE: all state here uses non-blocking assignments so every register sees
         // the pre-edge values of the others, regardless of statement order.
         case (state)
            FILL: begin
               if (in_valid) begin
                  blk[wi] <= in_word;
                  wi      <= wi + 4'd1;
                  wcnt    <= wcnt + CNT_W'(1);
                  if (in_last) begin
                     msg_end <= 1'b1;
                  end
                  if (wi == 4'd15) begin
                     // Block full; padding (if any) continues in the next block.
                     state     <= EMIT;
                     out_first <= first_pend;
                     out_last  <= 1'b0;
                  end else if (in_last) begin
                     state <= PAD;
                  end
               end
            end

            PAD: begin
               if (!pad_done) begin
                  blk[wi]  <= PAD_WORD;
                  pad_done <= 1'b1;
                  if (wi == 4'd14) begin
                     no_len <= 1'b1;
                  end
               end else if (no_len) begin
                  blk[wi] <= '0;
               end else if (wi == 4'd14) begin
                  blk[wi] <= len[63:32];
               end else if (wi == 4'd15) begin
                  blk[wi] <= len[31:0];
               end else begin
                  blk[wi] <= '0;
               end
               wi <= wi + 4'd1;
               if (wi == 4'd15) begin
                  // Only a block whose slots 14/15 received the length is final.
                  state     <= EMIT;
                  out_first <= first_pend;
                  out_last  <= pad_done && !no_len;
               end
            end

            EMIT: begin
               if (out_ready) begin
                  wi         <= '0;
                  first_pend <= 1'b0;
                  no_len     <= 1'b0;
                  if (out_last) begin
                     wcnt       <= '0;
                     pad_done   <= 1'b0;
                     msg_end    <= 1'b0;
                     first_pend <= 1'b1;
                     state      <= FILL;
                  end else if (msg_end) begin
                     state <= PAD;
                  end else begin
                     state <= FILL;
                  end
               end
            end

            default: state <= FILL;
         endcase
      end
   end

endmodule : sha256_msg_padder
